// File: rtl/gfx_bus_master_if.sv
// Host request/response and register-bus signal bundle for gfx_bus_master.
// The master modport is the initiator's view; slave is the host/adapter side.
interface gfx_bus_master_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [3:0] req_rs;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic       bus_phi2;
   logic       bus_cs_n;
   logic [3:0] bus_rs;
   logic       bus_wren;
   logic [7:0] bus_data_o;
   logic       bus_data_oe;
   logic [7:0] bus_data_i;

   modport master (
      input  req_valid, req_write, req_rs, req_wdata, bus_data_i,
      output req_ready, rsp_valid, rsp_rdata, busy,
      output bus_phi2, bus_cs_n, bus_rs, bus_wren, bus_data_o, bus_data_oe
   );

   modport slave (
      output req_valid, req_write, req_rs, req_wdata, bus_data_i,
      input  req_ready, rsp_valid, rsp_rdata, busy,
      input  bus_phi2, bus_cs_n, bus_rs, bus_wren, bus_data_o, bus_data_oe
   );
endinterface

// File: rtl/gfx_bus_master.sv
// Register-bus initiator: queues host read/write requests in a FIFO and replays
// each as a SETUP / phi2-HIGH / HOLD bus cycle with fully registered bus outputs.
module gfx_bus_master #(
   parameter int PHASE_CYCLES = 25,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   gfx_bus_master_if.master  io
);
   localparam int CNT_W = $clog2(PHASE_CYCLES);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int EW    = 13;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_HOLD} state_t;

   logic [EW-1:0]    r_mem [FIFO_DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [EW-1:0]    w_head;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_phase_end;
   logic             w_sample;

   logic             r_phi2;
   logic             r_cs_n;
   logic             r_wren;
   logic             r_data_oe;
   logic [3:0]       r_rs;
   logic [7:0]       r_data_o;
   logic             r_rsp_valid;
   logic [7:0]       r_rdata;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = io.req_valid && !w_full;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {io.req_write, io.req_rs, io.req_wdata};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign w_phase_end = (r_cnt == CNT_W'(PHASE_CYCLES - 1));
   // r_wren high inside a cycle marks a read; sample on the final HIGH clk.
   assign w_sample    = (r_state == ST_HIGH) && w_phase_end && r_wren;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = ST_SETUP;
               w_cnt_next   = '0;
            end
         end
         ST_SETUP: begin
            if (w_phase_end) begin
               w_state_next = ST_HIGH;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (w_phase_end) begin
               w_state_next = ST_HOLD;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next   = r_cnt + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            w_cnt_next = '0;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = ST_SETUP;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Bus pins are decoded from the next state so they change with the state flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cs_n      <= 1'b1;
         r_phi2      <= 1'b0;
         r_wren      <= 1'b1;
         r_rs        <= '0;
         r_data_o    <= '0;
         r_data_oe   <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_cs_n      <= (w_state_next == ST_IDLE);
         r_phi2      <= (w_state_next == ST_HIGH);
         r_rsp_valid <= w_sample;
         if (w_sample) r_rdata <= io.bus_data_i;
         if (w_pop) begin
            r_rs      <= w_head[11:8];
            r_wren    <= !w_head[12];
            r_data_oe <= w_head[12];
            r_data_o  <= w_head[12] ? w_head[7:0] : 8'h00;
         end else if (w_state_next == ST_IDLE) begin
            r_wren    <= 1'b1;
            r_data_oe <= 1'b0;
            r_data_o  <= 8'h00;
         end
      end
   end

   assign io.req_ready   = !w_full;
   assign io.rsp_valid   = r_rsp_valid;
   assign io.rsp_rdata   = r_rdata;
   assign io.busy        = !w_empty || (r_state != ST_IDLE);
   assign io.bus_phi2    = r_phi2;
   assign io.bus_cs_n    = r_cs_n;
   assign io.bus_rs      = r_rs;
   assign io.bus_wren    = r_wren;
   assign io.bus_data_o  = r_data_o;
   assign io.bus_data_oe = r_data_oe;
endmodule
